// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences one MULT or DIV operation on the external multiplier
// and divider units. It latches the operands, launches the selected unit,
// waits a bounded time for its stop flag, and commits the result to HI/LO.
// Divide-by-zero and timeout end the operation early with an error pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; operands and op latched when it arrives
// LAUNCH   | one-cycle launch pulse to the selected unit, counter cleared
// WAIT_MUL | waiting for multStop, counting cycles toward TIMEOUT
// WAIT_DIV | waiting for divStop, counting cycles toward TIMEOUT
// CAPTURE  | hi/lo hold the new result, done pulses
// ERR      | div0 or tmo pulses, hi/lo untouched
module muldiv_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        multStop,
  input  logic        divStop,
  input  logic [31:0] multHi,
  input  logic [31:0] multLo,
  input  logic [31:0] divHi,
  input  logic [31:0] divLo,
  output logic        multControl,
  output logic        divControl,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic        tmo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LAUNCH   = 3'd1,
    WAIT_MUL = 3'd2,
    WAIT_DIV = 3'd3,
    CAPTURE  = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          op_q;
  logic          err_div0;
  logic [CW-1:0] wait_cnt;
  logic          zero_div;

  assign zero_div = op && (b == '0);

  // State register; synchronous reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and all control outputs, decoded from the current state.
  // The cycle whose count equals TIMEOUT is still a valid completion cycle,
  // so a stop arriving exactly then wins over the timeout.
  always_comb begin
    state_nxt   = state;
    multControl = 1'b0;
    divControl  = 1'b0;
    done        = 1'b0;
    div0        = 1'b0;
    tmo         = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = start && !Reset;
        if (start) state_nxt = zero_div ? ERR : LAUNCH;
      end
      LAUNCH: begin
        multControl = !op_q;
        divControl  = op_q;
        state_nxt   = op_q ? WAIT_DIV : WAIT_MUL;
      end
      WAIT_MUL: begin
        if (multStop)                   state_nxt = CAPTURE;
        else if (wait_cnt == CNT_LIMIT) state_nxt = ERR;
      end
      WAIT_DIV: begin
        if (divStop)                    state_nxt = CAPTURE;
        else if (wait_cnt == CNT_LIMIT) state_nxt = ERR;
      end
      CAPTURE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        div0      = err_div0;
        tmo       = !err_div0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, wait counter and HI/LO. The unit result is written at the
  // edge the stop is seen, so hi/lo already show it while done is high.
  always_ff @(posedge clk) begin
    if (Reset) begin
      opA      <= '0;
      opB      <= '0;
      op_q     <= 1'b0;
      err_div0 <= 1'b0;
      wait_cnt <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opA      <= a;
            opB      <= b;
            op_q     <= op;
            err_div0 <= zero_div;
          end
        end
        LAUNCH: wait_cnt <= '0;
        WAIT_MUL: begin
          if (multStop) begin
            hi <= multHi;
            lo <= multLo;
          end else if (wait_cnt != CNT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DIV: begin
          if (divStop) begin
            hi <= divHi;
            lo <= divLo;
          end else if (wait_cnt != CNT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq. The bench plays the multiplier/divider,
// pushes the expected completion record when it issues a start, and the
// negedge monitor records every done/div0/tmo event for comparison.
module tb_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, op, mult_stop, div_stop, sel;
  logic [31:0] a, b, mult_hi, mult_lo, div_hi, div_lo;

  logic        m_mc, m_dc, m_busy, m_done, m_div0, m_tmo;
  logic [31:0] m_opa, m_opb, m_hi, m_lo;
  logic        t_mc, t_dc, t_busy, t_done, t_div0, t_tmo;
  logic [31:0] t_opa, t_opb, t_hi, t_lo;

  muldiv_seq u_main (
    .clk(clk), .Reset(rst), .start(start), .op(op), .a(a), .b(b),
    .multStop(mult_stop), .divStop(div_stop),
    .multHi(mult_hi), .multLo(mult_lo), .divHi(div_hi), .divLo(div_lo),
    .multControl(m_mc), .divControl(m_dc), .opA(m_opa), .opB(m_opb),
    .busy(m_busy), .done(m_done), .div0(m_div0), .tmo(m_tmo),
    .hi(m_hi), .lo(m_lo)
  );

  muldiv_seq #(.TIMEOUT(8)) u_tmo (
    .clk(clk), .Reset(rst), .start(start), .op(op), .a(a), .b(b),
    .multStop(mult_stop), .divStop(div_stop),
    .multHi(mult_hi), .multLo(mult_lo), .divHi(div_hi), .divLo(div_lo),
    .multControl(t_mc), .divControl(t_dc), .opA(t_opa), .opB(t_opb),
    .busy(t_busy), .done(t_done), .div0(t_div0), .tmo(t_tmo),
    .hi(t_hi), .lo(t_lo)
  );

  // Monitor follows whichever instance is selected.
  logic        o_mc, o_dc, o_done, o_div0, o_tmo;
  logic [31:0] o_hi, o_lo;
  assign o_mc   = sel ? t_mc   : m_mc;
  assign o_dc   = sel ? t_dc   : m_dc;
  assign o_done = sel ? t_done : m_done;
  assign o_div0 = sel ? t_div0 : m_div0;
  assign o_tmo  = sel ? t_tmo  : m_tmo;
  assign o_hi   = sel ? t_hi   : m_hi;
  assign o_lo   = sel ? t_lo   : m_lo;

  localparam logic [2:0] K_DONE = 3'b001;
  localparam logic [2:0] K_DIV0 = 3'b010;
  localparam logic [2:0] K_TMO  = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        b2b;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   mult_pulses = 0;
  int   div_pulses  = 0;
  logic prev_evt    = 1'b0;

  // Record launch pulses and completion events away from the clock edge.
  always @(negedge clk) begin
    rec_t r;
    if (o_mc) mult_pulses++;
    if (o_dc) div_pulses++;
    if (o_done || o_div0 || o_tmo) begin
      r.kind = {o_tmo, o_div0, o_done};
      r.hi   = o_hi;
      r.lo   = o_lo;
      r.b2b  = prev_evt;
      obs_q.push_back(r);
    end
    prev_evt = o_done || o_div0 || o_tmo;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [2:0] kind, input logic [31:0] h, input logic [31:0] l);
    rec_t e;
    e.kind = kind;
    e.hi   = h;
    e.lo   = l;
    e.b2b  = 1'b0;
    exp_q.push_back(e);
  endtask

  // Compare every recorded event with the scoreboard, then flag leftovers.
  task automatic drain(input string tag);
    rec_t r, e;
    while (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      chk({tag, "_back_to_back"}, 32'(r.b2b), 32'd0);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_mis++;
        $error("FAIL %s_unexpected_event: observed kind %b expected none", tag, r.kind);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_kind"}, 32'(r.kind), 32'(e.kind));
        chk({tag, "_hi"}, r.hi, e.hi);
        chk({tag, "_lo"}, r.lo, e.lo);
      end
    end
    chk({tag, "_missing_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic bus_idle();
    mult_stop = 1'b0;
    div_stop  = 1'b0;
    mult_hi   = 32'hDEADBEEF;
    mult_lo   = 32'hDEADBEEF;
    div_hi    = 32'hBAADF00D;
    div_lo    = 32'hBAADF00D;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    bus_idle();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  int mp0, dp0;

  initial begin
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h1234_5678;
    b     = 32'h9ABC_DEF0;
    bus_idle();

    // Reset wins over a held start; everything reads zero.
    tick();
    tick();
    chk("rst_state", {m_mc, m_dc, m_busy, m_done, m_div0, m_tmo}, 32'd0);
    chk("rst_opa", m_opa, 32'd0);
    chk("rst_opb", m_opb, 32'd0);
    chk("rst_hi", m_hi, 32'd0);
    chk("rst_lo", m_lo, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    drain("rst");

    // MULT 7 * -3, stop 33 cycles after launch.
    mp0 = mult_pulses; dp0 = div_pulses;
    a = 32'd7; b = 32'hFFFF_FFFD; op = 1'b0; start = 1'b1;
    #1;
    chk("mult_busy_on_start", 32'(m_busy), 32'd1);
    expect_evt(K_DONE, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    tick();
    start = 1'b0;
    chk("mult_launch", 32'(m_mc), 32'd1);
    chk("mult_opa", m_opa, 32'd7);
    chk("mult_opb", m_opb, 32'hFFFF_FFFD);
    repeat (33) tick();
    chk("mult_not_done_early", 32'(m_done), 32'd0);
    mult_stop = 1'b1; mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFEB;
    tick();
    bus_idle();
    chk("mult_done_n1", 32'(m_done), 32'd1);
    chk("mult_hi_n1", m_hi, 32'hFFFF_FFFF);
    chk("mult_busy_n1", 32'(m_busy), 32'd1);
    tick();
    chk("mult_busy_n2", 32'(m_busy), 32'd0);
    chk("mult_done_n2", 32'(m_done), 32'd0);
    drain("mult");
    chk("mult_pulses", 32'(mult_pulses - mp0), 32'd1);
    chk("mult_no_div_pulse", 32'(div_pulses - dp0), 32'd0);

    // DIV 100 / 7.
    mp0 = mult_pulses; dp0 = div_pulses;
    a = 32'd100; b = 32'd7; op = 1'b1; start = 1'b1;
    expect_evt(K_DONE, 32'd2, 32'd14);
    tick();
    start = 1'b0;
    repeat (5) tick();
    div_stop = 1'b1; div_hi = 32'd2; div_lo = 32'd14;
    tick();
    bus_idle();
    chk("div_done", 32'(m_done), 32'd1);
    tick();
    drain("div");
    chk("div_hi", m_hi, 32'd2);
    chk("div_lo", m_lo, 32'd14);
    chk("div_pulses", 32'(div_pulses - dp0), 32'd1);
    chk("div_no_mult_pulse", 32'(mult_pulses - mp0), 32'd0);

    // Divide by zero: straight to ERR, no launch.
    mp0 = mult_pulses; dp0 = div_pulses;
    a = 32'd5; b = 32'd0; op = 1'b1; start = 1'b1;
    expect_evt(K_DIV0, 32'd2, 32'd14);
    tick();
    start = 1'b0;
    chk("div0_pulse", 32'(m_div0), 32'd1);
    chk("div0_busy", 32'(m_busy), 32'd1);
    tick();
    chk("div0_busy_after", 32'(m_busy), 32'd0);
    tick();
    drain("div0");
    chk("div0_no_launch", 32'(div_pulses - dp0 + mult_pulses - mp0), 32'd0);
    chk("div0_hi_kept", m_hi, 32'd2);

    // start held through WAIT_DIV plus spurious multStop.
    mp0 = mult_pulses; dp0 = div_pulses;
    a = 32'd50; b = 32'd5; op = 1'b1; start = 1'b1;
    expect_evt(K_DONE, 32'd0, 32'd10);
    tick();
    a = 32'd999; b = 32'd0; op = 1'b0;
    tick();
    mult_stop = 1'b1; mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
    repeat (3) tick();
    chk("hold_opa", m_opa, 32'd50);
    chk("hold_opb", m_opb, 32'd5);
    chk("hold_no_done", 32'(m_done), 32'd0);
    bus_idle();
    start = 1'b0;
    div_stop = 1'b1; div_hi = 32'd0; div_lo = 32'd10;
    tick();
    bus_idle();
    repeat (4) tick();
    drain("hold");
    chk("hold_div_pulses", 32'(div_pulses - dp0), 32'd1);
    chk("hold_mult_pulses", 32'(mult_pulses - mp0), 32'd0);

    // Reset mid-WAIT_MUL with a coincident and a late stop.
    a = 32'd9; b = 32'd9; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    mult_stop = 1'b1; mult_hi = 32'h3333_3333; mult_lo = 32'h4444_4444;
    tick();
    rst = 1'b0;
    tick();
    bus_idle();
    tick();
    drain("rst_mid");
    chk("rst_mid_hi", m_hi, 32'd0);
    chk("rst_mid_lo", m_lo, 32'd0);
    chk("rst_mid_opa", m_opa, 32'd0);
    chk("rst_mid_busy", 32'(m_busy), 32'd0);

    // TIMEOUT=8 instance: stop exactly at count 8 completes normally.
    sel = 1'b1;
    do_reset();
    drain("tmo_rst");
    a = 32'd3; b = 32'd4; op = 1'b0; start = 1'b1;
    expect_evt(K_DONE, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("edge_no_tmo_yet", 32'(t_tmo), 32'd0);
    mult_stop = 1'b1; mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555;
    tick();
    bus_idle();
    chk("edge_done", 32'(t_done), 32'd1);
    chk("edge_tmo", 32'(t_tmo), 32'd0);
    tick();
    drain("tmo_edge");

    // No stop at all: tmo after the count reaches 8, hi/lo unchanged.
    a = 32'd6; b = 32'd6; op = 1'b0; start = 1'b1;
    expect_evt(K_TMO, 32'hAAAA_AAAA, 32'h5555_5555);
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("tmo_not_yet", 32'(t_tmo), 32'd0);
    chk("tmo_busy_wait", 32'(t_busy), 32'd1);
    tick();
    chk("tmo_pulse", 32'(t_tmo), 32'd1);
    chk("tmo_no_done", 32'(t_done), 32'd0);
    tick();
    chk("tmo_busy_idle", 32'(t_busy), 32'd0);
    tick();
    drain("tmo");
    chk("tmo_hi_kept", t_hi, 32'hAAAA_AAAA);
    chk("tmo_lo_kept", t_lo, 32'h5555_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles spent waiting for a unit stop before aborting.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  operation request from CPU control unit, sampled in IDLE only.
REQ-005 SHALL have port op  input  1  0 = MULT, 1 = DIV.
REQ-006 SHALL have ports a, b  input  32 each  source operands, sampled with start.
REQ-007 SHALL have ports multStop, divStop  input  1 each  completion flags from multiplier/divider.
REQ-008 SHALL have ports multHi, multLo, divHi, divLo  input  32 each  unit results, valid while the matching stop is high.
REQ-009 SHALL have ports multControl, divControl  output  1 each  one-cycle launch pulses to the units.
REQ-010 SHALL have ports opA, opB  output  32 each  latched operands driven to both units.
REQ-011 SHALL have ports busy  output  1  CPU stall request; done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports div0  output  1  divide-by-zero pulse; tmo  output  1  timeout pulse.
REQ-013 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_MUL, WAIT_DIV, CAPTURE, ERR.
REQ-015 IDLE: start=1 SHALL latch a->opA, b->opB, op; go LAUNCH, except op=1 with b=0 goes ERR.
REQ-016 LAUNCH: SHALL assert multControl (op=0) or divControl (op=1) for exactly this cycle; clear wait counter; go WAIT_MUL/WAIT_DIV.
REQ-017 WAIT_MUL: multStop=1 SHALL capture multHi/multLo internally and go CAPTURE; divStop SHALL be ignored.
REQ-018 WAIT_DIV: divStop=1 SHALL capture divHi/divLo internally and go CAPTURE; multStop SHALL be ignored.
REQ-019 WAIT states: counter SHALL increment each cycle without stop; on reaching TIMEOUT go ERR with tmo flagged, hi/lo unchanged.
REQ-020 A stop arriving the same cycle the counter reaches TIMEOUT SHALL win (normal completion, no tmo).
REQ-021 CAPTURE: SHALL write captured values to hi/lo, pulse done for one cycle, return to IDLE.
REQ-022 ERR: SHALL pulse div0 (zero divisor) or tmo (timeout) for one cycle, hi/lo unchanged, no launch pulse, return to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE; combinational busy SHALL also be 1 in IDLE in the cycle start=1 is sampled.
REQ-024 start while not in IDLE SHALL be ignored (no queueing).
REQ-025 Stop flags in IDLE, LAUNCH, CAPTURE or ERR SHALL be ignored.
REQ-026 Latency: start at cycle 0, stop observed at cycle N, hi/lo updated and done=1 at cycle N+1; busy falls at N+2.
REQ-027 opA/opB SHALL hold stable from LAUNCH until return to IDLE.
REQ-028 done, div0, tmo SHALL be mutually exclusive and never high two consecutive cycles.

Reset
REQ-029 Reset=1 SHALL, at the next edge, force IDLE, clear counter, and drive multControl=divControl=busy=done=div0=tmo=0, opA=opB=hi=lo=0.
REQ-030 Reset SHALL take priority over start and stop in the same cycle, including mid-operation; an in-flight result SHALL be discarded.

Verification
REQ-031 MULT: a=7, b=-3, multStop after 33 cycles with multHi=FFFFFFFF, multLo=FFFFFFEB -> one multControl pulse, hi=FFFFFFFF, lo=FFFFFFEB, done one cycle.
REQ-032 DIV: a=100, b=7, divStop with divHi=2, divLo=14 -> one divControl pulse, hi=2, lo=14, no multControl.
REQ-033 DIV by zero: a=5, b=0 -> div0 pulse, no divControl, hi/lo keep prior values, busy high 1 cycle in ERR.
REQ-034 Timeout: TIMEOUT=8, MULT, multStop never set -> tmo pulse after 8 wait cycles, hi/lo unchanged; stop at exactly count 8 -> done, no tmo.
REQ-035 Reset mid-WAIT_MUL then multStop -> outputs all zero, no done, hi/lo stay 0.
REQ-036 start held high during WAIT_DIV and spurious multStop -> ignored; exactly one completion observed.
